// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with sub-word read-modify-write
//
// Purpose: accepts one load or store per request, handles byte/halfword/word
// sizes with little-endian lanes, sign/zero extension on loads, and merges
// sub-word stores into the containing word via a read-modify-write cycle.
// The data memory has a registered read port (one cycle read latency).
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready low = stall)
//   req_we, req_size, req_signed      store/load, size (00 b, 01 h, 1x w), extension
//   req_addr, req_wdata               byte address, right-aligned store data
//   resp_valid, resp_rdata            one-cycle completion pulse and load result
//   misalign_err                      completion was a misaligned access
//   dmem_we, dmem_addr, dmem_wdata    data memory write enable, word address, write data
//   dmem_rdata                        data memory read data (one cycle after address)

module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign_err,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WAIT  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] cap_addr;
   logic [15:0] cap_wdata;
   logic [1:0]  cap_size;
   logic        cap_signed;

   logic        accept;
   logic        req_word;
   logic        req_half;
   logic        misaligned;
   logic        cap_word;
   logic        cap_half;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign req_ready  = (state == IDLE);
   assign accept     = req_valid & req_ready;

   // Size 11 is treated as a word access.
   assign req_word   = req_size[1];
   assign req_half   = (req_size == 2'b01);
   assign misaligned = (req_half & req_addr[0]) | (req_word & (req_addr[1:0] != 2'b00));

   assign cap_word   = cap_size[1];
   assign cap_half   = (cap_size == 2'b01);

   // In IDLE the memory sees the incoming request address so that the read
   // data is available in the following (wait) cycle.
   assign dmem_addr  = (state == IDLE) ? {req_addr[31:2], 2'b00} : {cap_addr[31:2], 2'b00};

   // Write happens either directly for an aligned word store, or in the
   // RMW wait cycle with the merged word. Reset forces it low asynchronously.
   assign dmem_we    = rst_n & ((state == RMW_WAIT) |
                                (accept & req_we & req_word & ~misaligned));

   assign dmem_wdata = (state == IDLE) ? req_wdata : merged;

   // Lane selection and extension of the returned word, using captured fields.
   always_comb begin
      sel_byte = dmem_rdata[{cap_addr[1:0], 3'b000} +: 8];
      sel_half = dmem_rdata[{cap_addr[1], 4'b0000} +: 16];
      load_ext = dmem_rdata;
      if (cap_half)
         load_ext = {{16{cap_signed & sel_half[15]}}, sel_half};
      else if (!cap_word)
         load_ext = {{24{cap_signed & sel_byte[7]}}, sel_byte};
   end

   // Replace the addressed lane of the old word with the captured store data.
   always_comb begin
      merged = dmem_rdata;
      if (cap_half)
         merged[{cap_addr[1], 4'b0000} +: 16] = cap_wdata;
      else if (!cap_word)
         merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cap_addr     <= 32'd0;
         cap_wdata    <= 16'd0;
         cap_size     <= 2'd0;
         cap_signed   <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'd0;
         misalign_err <= 1'b0;
      end else begin
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'd0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_addr   <= req_addr;
                  cap_wdata  <= req_wdata[15:0];
                  cap_size   <= req_size;
                  cap_signed <= req_signed;
                  if (misaligned) begin
                     resp_valid   <= 1'b1;
                     misalign_err <= 1'b1;
                  end else if (req_we && req_word) begin
                     resp_valid <= 1'b1;
                  end else if (req_we) begin
                     state <= RMW_WAIT;
                  end else begin
                     state <= LOAD_WAIT;
                  end
               end
            end
            LOAD_WAIT: begin
               resp_valid <= 1'b1;
               resp_rdata <= load_ext;
               state      <= IDLE;
            end
            RMW_WAIT: begin
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign_err;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   int checks;
   int failures;
   int we_cnt;
   int resp_cnt;

   logic [31:0] mem [0:63];

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .misalign_err (misalign_err),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with registered read port; a same-edge write returns old data.
   always @(posedge clk) begin
      if (dmem_we) mem[dmem_addr[7:2]] <= dmem_wdata;
      dmem_rdata <= mem[dmem_addr[7:2]];
   end

   always @(posedge clk) begin
      if (dmem_we)    we_cnt++;
      if (resp_valid) resp_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // Lets the accept edge pass, then waits (bounded) for the response pulse.
   // lat counts edges from the accept edge inclusive; busy counts stall cycles.
   task automatic finish_op(output logic got, output logic [31:0] rd, output logic err,
                            output int lat, output int busy);
      got = 1'b0; rd = 32'd0; err = 1'b0; lat = 0; busy = 0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 1; i <= 6 && !got; i++) begin
         if (resp_valid) begin
            got = 1'b1; rd = resp_rdata; err = misalign_err; lat = i;
         end else begin
            if (!req_ready) busy++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got, output logic [31:0] rd, output logic err,
                        output int lat, output int busy);
      issue(we, size, sgn, addr, wdata);
      finish_op(got, rd, err, lat, busy);
   endtask

   task automatic test_reset;
      logic got, err; logic [31:0] rd; int lat, busy;
      rst_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h4; req_wdata = 32'h1234_5678;
      repeat (2) @(negedge clk);
      checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL reset_dmem_we got=%b exp=0", dmem_we); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
      checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++; if (we_cnt !== 0) begin failures++; $display("FAIL reset_no_write got=%0d exp=0", we_cnt); end
      // First accept on the first edge after release.
      req_addr = 32'h4; req_wdata = 32'hCAFE_F00D;
      rst_n = 1'b1;
      finish_op(got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 1) begin failures++; $display("FAIL first_accept got=%b lat=%0d exp=1/1", got, lat); end
      checks++; if (mem[1] !== 32'hCAFE_F00D) begin failures++; $display("FAIL first_accept_mem got=%h exp=cafef00d", mem[1]); end
   endtask

   task automatic test_word;
      logic got, err; logic [31:0] rd; int lat, busy, we0;
      we0 = we_cnt;
      issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
      #1;
      checks++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h8 || dmem_wdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL sw_accept_cycle we=%b addr=%h wdata=%h exp=1/00000008/deadbeef", dmem_we, dmem_addr, dmem_wdata); end
      finish_op(got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 1 || rd !== 32'd0 || err !== 1'b0) begin
         failures++; $display("FAIL sw_resp got=%b lat=%0d rd=%h err=%b exp=1/1/0/0", got, lat, rd, err); end
      #10;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sw_single_pulse got=%b exp=0", resp_valid); end
      checks++; if (we_cnt - we0 !== 1) begin failures++; $display("FAIL sw_we_cycles got=%0d exp=1", we_cnt - we0); end
      do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 2 || rd !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL lw_resp got=%b lat=%0d rd=%h exp=1/2/deadbeef", got, lat, rd); end
      checks++; if (we_cnt - we0 !== 1) begin failures++; $display("FAIL lw_no_write got=%0d exp=1", we_cnt - we0); end
   endtask

   task automatic test_byte;
      logic got, err; logic [31:0] rd; int lat, busy;
      do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, got, rd, err, lat, busy);
      do_op(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 2 || busy !== 1 || rd !== 32'd0) begin
         failures++; $display("FAIL sb_resp got=%b lat=%0d busy=%0d rd=%h exp=1/2/1/0", got, lat, busy, rd); end
      checks++; if (mem[4] !== 32'h11AA_3344) begin failures++; $display("FAIL sb_mem got=%h exp=11aa3344", mem[4]); end
      do_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'hFFFF_FFAA || lat !== 2) begin failures++; $display("FAIL lb_signed got=%h lat=%0d exp=ffffffaa/2", rd, lat); end
      do_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'h0000_00AA) begin failures++; $display("FAIL lbu got=%h exp=000000aa", rd); end
      do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'h0000_0011) begin failures++; $display("FAIL lb_lane3 got=%h exp=00000011", rd); end
   endtask

   task automatic test_half;
      logic got, err; logic [31:0] rd; int lat, busy;
      do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF, got, rd, err, lat, busy);
      do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8001", rd); end
      do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'h0000_7FFF) begin failures++; $display("FAIL lhu got=%h exp=00007fff", rd); end
      do_op(1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD_1234, got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 2) begin failures++; $display("FAIL sh_resp got=%b lat=%0d exp=1/2", got, lat); end
      do_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'h8001_1234) begin failures++; $display("FAIL sh_merge got=%h exp=80011234", rd); end
   endtask

   task automatic test_misalign;
      logic got, err; logic [31:0] rd; int lat, busy, we0;
      we0 = we_cnt;
      issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
      finish_op(got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 1 || err !== 1'b1 || rd !== 32'd0) begin
         failures++; $display("FAIL lw_misalign got=%b lat=%0d err=%b rd=%h exp=1/1/1/0", got, lat, err, rd); end
      issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h5555);
      #1;
      checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL sh_misalign_we got=%b exp=0", dmem_we); end
      finish_op(got, rd, err, lat, busy);
      checks++; if (got !== 1'b1 || lat !== 1 || err !== 1'b1 || rd !== 32'd0) begin
         failures++; $display("FAIL sh_misalign got=%b lat=%0d err=%b rd=%h exp=1/1/1/0", got, lat, err, rd); end
      #10;
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign_err); end
      checks++; if (we_cnt !== we0) begin failures++; $display("FAIL misalign_no_write got=%0d exp=%0d", we_cnt, we0); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] op_addr [8];
      logic [31:0] op_wdata [8];
      logic        op_we [8];
      logic [31:0] exp_rd [8];
      int issued, acc, resp, cyc, last_cyc, r0;
      for (int i = 0; i < 8; i++) begin
         op_we[i]    = (i % 2 == 0);
         op_addr[i]  = (i % 2 == 0) ? 32'h30 + 32'(i / 2) : 32'h30;
         op_wdata[i] = 32'h11 * 32'(i / 2 + 1);
      end
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0000_0011;
      exp_rd[2] = 32'h0; exp_rd[3] = 32'h0000_2211;
      exp_rd[4] = 32'h0; exp_rd[5] = 32'h0033_2211;
      exp_rd[6] = 32'h0; exp_rd[7] = 32'h4433_2211;
      issued = 0; acc = 0; resp = 0; cyc = 0; last_cyc = -1;
      r0 = resp_cnt;
      @(negedge clk);
      while (resp < 8 && cyc < 100) begin
         if (resp_valid) begin
            checks++; if (resp_rdata !== exp_rd[resp] || misalign_err !== 1'b0) begin
               failures++; $display("FAIL b2b_resp%0d got=%h err=%b exp=%h/0", resp, resp_rdata, misalign_err, exp_rd[resp]); end
            resp++;
            last_cyc = cyc;
         end
         req_valid = 1'b1;
         if (issued < 8 && req_ready) begin
            req_we = op_we[issued]; req_size = op_we[issued] ? 2'b00 : 2'b10;
            req_signed = 1'b0; req_addr = op_addr[issued]; req_wdata = op_wdata[issued];
            issued++; acc++;
         end else if (issued >= 8) begin
            req_valid = 1'b0;
         end else begin
            // Stalled: scramble inputs, which must be ignored.
            req_we = 1'b1; req_size = 2'($urandom_range(0, 3)); req_signed = 1'b1;
            req_addr = 32'($urandom_range(0, 255)); req_wdata = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      checks++; if (resp !== acc || acc !== 8) begin failures++; $display("FAIL b2b_count resp=%0d acc=%0d exp=8/8", resp, acc); end
      checks++; if (resp_cnt - r0 !== 8) begin failures++; $display("FAIL b2b_pulses got=%0d exp=8", resp_cnt - r0); end
      checks++; if (last_cyc !== 16) begin failures++; $display("FAIL b2b_no_bubble last=%0d exp=16", last_cyc); end
   endtask

   task automatic test_reset_mid_rmw;
      logic got, err; logic [31:0] rd; int lat, busy, we0, r0;
      do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788, got, rd, err, lat, busy);
      issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00FF);
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0 || dmem_we !== 1'b1) begin
         failures++; $display("FAIL rmw_wait_state ready=%b we=%b exp=0/1", req_ready, dmem_we); end
      we0 = we_cnt; r0 = resp_cnt;
      rst_n = 1'b0;
      #1;
      checks++; if (dmem_we !== 1'b0) begin failures++; $display("FAIL rst_async_we got=%b exp=0", dmem_we); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++; $display("FAIL rst_release ready=%b resp=%b exp=1/0", req_ready, resp_valid); end
      checks++; if (we_cnt !== we0 || resp_cnt !== r0) begin
         failures++; $display("FAIL rst_abandon writes=%0d resps=%0d exp=0/0", we_cnt - we0, resp_cnt - r0); end
      do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got, rd, err, lat, busy);
      checks++; if (rd !== 32'h5566_7788) begin failures++; $display("FAIL rst_mem_intact got=%h exp=55667788", rd); end
   endtask

   initial begin
      checks = 0; failures = 0; we_cnt = 0; resp_cnt = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_misalign;
      test_back_to_back;
      test_reset_mid_rmw;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
